// File: rtl/led_scan_capture.sv
// Receive-side decoder for the 6x6 multiplexed LED scan bus: synchronizes the
// scan lines, latches settled slots and re-assembles/validates the time words.
module led_scan_capture #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  rows_in,
    input  logic [5:0]  columns_in,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [11:0] hours_raw,
    output logic [11:0] min_coarse_raw,
    output logic [11:0] sec_coarse_raw,
    output logic [3:0]  hours_bin,
    output logic [3:0]  min_coarse_bin,
    output logic [3:0]  sec_coarse_bin,
    output logic [7:0]  err_count
);

    localparam logic [3:0]  SETTLE_C = 4'(SETTLE);
    localparam logic [5:0]  ROW_TOP  = 6'b100000;
    localparam logic [11:0] RAW_RST  = 12'b100000000000;

    typedef enum logic {HUNT, COLLECT} state_t;

    function automatic logic onehot12(input logic [11:0] w);
        return (w != '0) && ((w & (w - 12'd1)) == '0);
    endfunction

    function automatic logic [3:0] decode12(input logic [11:0] w);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 12; i++)
            if (w[i]) b = 4'(11 - i);
        return b;
    endfunction

    logic [5:0]      rows_p0, rows_p1, cols_p0, cols_p1;
    logic [3:0]      stab_cnt;
    logic            stable, latch_now;
    logic [5:0]      lat_row_p2, lat_col_p2;
    logic            vld_p2;

    // Stage p0/p1: two-flop synchronizers and stability counter
    assign stable    = ({rows_p0, cols_p0} == {rows_p1, cols_p1});
    assign latch_now = stable && (stab_cnt == SETTLE_C - 4'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_p0  <= '0;
            rows_p1  <= '0;
            cols_p0  <= '0;
            cols_p1  <= '0;
            stab_cnt <= '0;
            vld_p2   <= 1'b0;
        end else begin
            rows_p0 <= rows_in;
            rows_p1 <= rows_p0;
            cols_p0 <= columns_in;
            cols_p1 <= cols_p0;
            if (!stable)
                stab_cnt <= '0;
            else if (stab_cnt != SETTLE_C)
                stab_cnt <= stab_cnt + 4'd1;
            vld_p2 <= latch_now;
        end
    end

    // Stage p2: latched slot
    always_ff @(posedge clk) begin
        if (latch_now) begin
            lat_row_p2 <= rows_p1;
            lat_col_p2 <= cols_p1;
        end
    end

    // Stage p3: frame assembly FSM and registered outputs
    state_t          state, state_n;
    logic [2:0]      idx, idx_n;
    logic [5:0][5:0] halves, halves_n;
    logic [5:0]      exp_row;
    logic [11:0]     word_h, word_m, word_s;
    logic            valid_n, err_n;
    logic [11:0]     hr_n, mr_n, sr_n;
    logic [3:0]      hb_n, mb_n, sb_n;
    logic [7:0]      errcnt_n;

    // The final half-word is taken straight from the latch so the check lands one edge after it.
    assign word_h  = {halves[0], halves[1]};
    assign word_m  = {halves[2], halves[3]};
    assign word_s  = {halves[4], lat_col_p2};
    assign exp_row = ROW_TOP >> idx;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        halves_n = halves;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        hr_n     = hours_raw;
        mr_n     = min_coarse_raw;
        sr_n     = sec_coarse_raw;
        hb_n     = hours_bin;
        mb_n     = min_coarse_bin;
        sb_n     = sec_coarse_bin;
        if (vld_p2) begin
            case (state)
                HUNT: begin
                    if (lat_row_p2 == ROW_TOP) begin
                        halves_n[0] = lat_col_p2;
                        idx_n       = 3'd1;
                        state_n     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (lat_row_p2 == exp_row) begin
                        halves_n[idx] = lat_col_p2;
                        if (idx == 3'd5) begin
                            state_n = HUNT;
                            idx_n   = 3'd0;
                            if (onehot12(word_h) && onehot12(word_m) && onehot12(word_s)) begin
                                valid_n = 1'b1;
                                hr_n    = word_h;
                                mr_n    = word_m;
                                sr_n    = word_s;
                                hb_n    = decode12(word_h);
                                mb_n    = decode12(word_m);
                                sb_n    = decode12(word_s);
                            end else begin
                                err_n = 1'b1;
                            end
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        err_n = 1'b1;
                        if (lat_row_p2 == ROW_TOP) begin
                            halves_n[0] = lat_col_p2;
                            idx_n       = 3'd1;
                        end else begin
                            state_n = HUNT;
                            idx_n   = 3'd0;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    idx_n   = 3'd0;
                end
            endcase
        end
        errcnt_n = (err_n && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    end

    always_ff @(posedge clk) begin
        halves <= halves_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HUNT;
            idx            <= '0;
            frame_valid    <= 1'b0;
            frame_err      <= 1'b0;
            hours_raw      <= RAW_RST;
            min_coarse_raw <= RAW_RST;
            sec_coarse_raw <= RAW_RST;
            hours_bin      <= '0;
            min_coarse_bin <= '0;
            sec_coarse_bin <= '0;
            err_count      <= '0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            frame_valid    <= valid_n;
            frame_err      <= err_n;
            hours_raw      <= hr_n;
            min_coarse_raw <= mr_n;
            sec_coarse_raw <= sr_n;
            hours_bin      <= hb_n;
            min_coarse_bin <= mb_n;
            sec_coarse_bin <= sb_n;
            err_count      <= errcnt_n;
        end
    end

endmodule
